// File: rtl/stream_unpack_pkg.sv
// Shared helpers for stream_unpack.
//   state_e    : control state of the unpacker (no word held / word held).
//   idx_width  : width of the beat-index counter for a given ratio (at least 1 bit).
//   slice_sel  : which slice of the wide word carries beat k, honouring emit order.
package stream_unpack_pkg;

  typedef enum logic {
    StEmpty = 1'b0,
    StBusy  = 1'b1
  } state_e;

  function automatic int unsigned idx_width(input int unsigned ratio);
    return (ratio <= 1) ? 1 : unsigned'($clog2(ratio));
  endfunction

  // Beat k maps to slice k (lowest first) or slice ratio-1-k (highest first).
  function automatic int unsigned slice_sel(input int unsigned k, input int unsigned ratio,
                                            input bit msb_first);
    return msb_first ? (ratio - 1 - k) : k;
  endfunction

endpackage

// File: rtl/stream_unpack.sv
// Width down-converter: takes one OUT_W*RATIO word and emits RATIO beats of OUT_W bits.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   wdata_i/wvalid_i     : wide input word and its valid
//   wready_o             : word accepted this cycle (combinational from rready_i)
//   rdata_o/rvalid_o     : registered output beat and its valid
//   rready_i             : downstream accepts the beat
//   rlast_o              : current beat is the final slice of its word
module stream_unpack
  import stream_unpack_pkg::*;
#(
  parameter int unsigned OUT_W     = 64,
  parameter int unsigned RATIO     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [OUT_W*RATIO-1:0] wdata_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  output logic [OUT_W-1:0]       rdata_o,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic                   rlast_o
);

  localparam int unsigned     IdxW    = idx_width(RATIO);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(RATIO - 1);

  state_e                      state_q, state_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic [OUT_W-1:0]            rdata_q, rdata_d;
  logic                        rlast_q, rlast_d;
  logic [RATIO-1:0][OUT_W-1:0] word_q;
  logic [RATIO-1:0][OUT_W-1:0] wdata_beats;
  logic                        w_fire, r_fire;

  function automatic logic [OUT_W-1:0] pick(input logic [RATIO-1:0][OUT_W-1:0] w,
                                            input logic [IdxW-1:0] k);
    return w[IdxW'(slice_sel(32'(k), RATIO, MSB_FIRST))];
  endfunction

  assign wdata_beats = wdata_i;
  assign rvalid_o    = (state_q == StBusy);
  assign rdata_o     = rdata_q;
  assign rlast_o     = rlast_q;
  assign r_fire      = rvalid_o && rready_i;
  // A new word may enter on the same edge the last beat leaves, so there is no bubble.
  assign wready_o    = (state_q == StEmpty) || (r_fire && rlast_q);
  assign w_fire      = wvalid_i && wready_o;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      idx_q   <= '0;
      rdata_q <= '0;
      rlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      rlast_q <= rlast_d;
    end
  end

  // Held word carries no control meaning, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_fire) begin
      word_q <= wdata_beats;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StEmpty: begin
        if (w_fire) begin
          state_d = StBusy;
          idx_d   = '0;
        end
      end
      StBusy: begin
        if (r_fire) begin
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = w_fire ? StBusy : StEmpty;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: begin
        state_d = StEmpty;
        idx_d   = '0;
      end
    endcase
  end

  // Output register next values; a freshly captured word supplies beat 0 straight from wdata_i.
  always_comb begin
    rdata_d = '0;
    rlast_d = 1'b0;
    if (w_fire) begin
      rdata_d = pick(wdata_beats, '0);
      rlast_d = (IdxLast == '0);
    end else if (state_d == StBusy) begin
      rdata_d = pick(word_q, idx_d);
      rlast_d = (idx_d == IdxLast);
    end
  end

endmodule
